// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU, with a one-entry
// registered response slot and saturating per-requester transaction counters.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  logic        last_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  logic gnt_valid;
  logic gnt_id;
  logic can_issue;
  logic xfer;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign can_issue  = ~rsp_valid_q | rsp_ready;
  assign req0_ready = gnt_valid & ~gnt_id & can_issue & ~reset;
  assign req1_ready = gnt_valid & gnt_id & can_issue & ~reset;
  assign xfer       = req0_ready | req1_ready;

  // Operands follow the grant even when the response slot is blocked.
  always_comb begin
    alu_op = 4'd0;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    if (gnt_valid) begin
      if (gnt_id) begin
        alu_op = req1_op;
        alu_a  = req1_a;
        alu_b  = req1_b;
      end else begin
        alu_op = req0_op;
        alu_a  = req0_a;
        alu_b  = req0_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'd0;
      cnt0_q      <= 16'd0;
      cnt1_q      <= 16'd0;
      last_q      <= 1'b1;
    end else begin
      if (xfer) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= gnt_id;
        rsp_data_q  <= alu_result;
        last_q      <= gnt_id;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      if (req0_ready && (cnt0_q != 16'hFFFF)) begin
        cnt0_q <= cnt0_q + 16'd1;
      end
      if (req1_ready && (cnt1_q != 16'hFFFF)) begin
        cnt1_q <= cnt1_q + 16'd1;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic, compared
// against a transaction-level reference model of the arbiter and response slot.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [15:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic        m_valid;
  logic        m_id;
  logic [31:0] m_data;
  int          m_cnt[2];
  int          m_last;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      default: return a ^ b ^ {28'd0, op};
    endcase
  endfunction

  // Shared combinational ALU stand-in
  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_id     = 1'b0;
    m_data   = 32'd0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_last   = 1;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registers.
  task automatic cycle();
    int          win;
    bit          slot_free;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b;
    @(negedge clk);
    if (req0_valid && req1_valid) win = 1 - m_last;
    else if (req0_valid)          win = 0;
    else if (req1_valid)          win = 1;
    else                          win = -1;
    slot_free = !m_valid || rsp_ready;
    e_op = 4'd0; e_a = 32'd0; e_b = 32'd0;
    if (win == 0) begin e_op = req0_op; e_a = req0_a; e_b = req0_b; end
    if (win == 1) begin e_op = req1_op; e_a = req1_a; e_b = req1_b; end
    check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, (win == 0) && slot_free && !reset});
    check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, (win == 1) && slot_free && !reset});
    check_eq("alu_op", {28'd0, alu_op}, {28'd0, e_op});
    check_eq("alu_a", alu_a, e_a);
    check_eq("alu_b", alu_b, e_b);
    if (reset) begin
      model_reset();
    end else if (win >= 0 && slot_free) begin
      m_valid = 1'b1;
      m_id    = win[0];
      m_data  = alu_fn(e_op, e_a, e_b);
      m_last  = win;
      if (m_cnt[win] < 65535) m_cnt[win]++;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
    check_eq("rsp_data", rsp_data, m_data);
    check_eq("cnt0", {16'd0, cnt0}, m_cnt[0]);
    check_eq("cnt1", {16'd0, cnt1}, m_cnt[1]);
  endtask

  task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic v1, input logic [3:0] op1,
                       input logic [31:0] a1, input logic [31:0] b1, input logic rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();
    do_reset();
    check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("reset_cnt0", {16'd0, cnt0}, 32'd0);

    // Single add from requester 0
    drive(1, 4'd0, 32'd5, 32'd7, 0, 0, 0, 0, 1);
    cycle();
    check_eq("add_rsp_data", rsp_data, 32'd12);
    check_eq("add_rsp_id", {31'd0, rsp_id}, 32'd0);
    check_eq("add_cnt0", {16'd0, cnt0}, 32'd1);

    // Both requesters continuously valid from reset: grants alternate 0,1,0,1
    do_reset();
    drive(1, 4'd0, 32'd100, 32'd1, 1, 4'd1, 32'd200, 32'd2, 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("rr_owner", {31'd0, rsp_id}, i % 2);
    end
    check_eq("rr_cnt0", {16'd0, cnt0}, 32'd2);
    check_eq("rr_cnt1", {16'd0, cnt1}, 32'd2);

    // Backpressure: slot holds, nothing accepted
    rsp_ready = 1'b0;
    cycle();
    held = rsp_data;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_data_held", rsp_data, held);
    end
    rsp_ready = 1'b1;
    cycle();
    check_eq("bp_refill_valid", {31'd0, rsp_valid}, 32'd1);

    // Requester 1 subtract, then idle bus
    drive(0, 0, 0, 0, 1, 4'd1, 32'd3, 32'd10, 1);
    cycle();
    check_eq("sub_rsp_data", rsp_data, 32'hFFFF_FFF9);
    check_eq("sub_rsp_id", {31'd0, rsp_id}, 32'd1);
    drive(0, 4'd5, 32'd9, 32'd9, 0, 4'd6, 32'd8, 32'd8, 1);
    cycle();
    cycle();

    // Reset while a response is stalled discards it; the next tie goes to requester 0
    drive(1, 4'd2, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 4'd3, 32'd1, 32'd2, 1, 4'd4, 32'd3, 32'd4, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_discard_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_discard_cnt1", {16'd0, cnt1}, 32'd0);
    rsp_ready = 1'b1;
    cycle();
    check_eq("rst_tie_owner", {31'd0, rsp_id}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom,
            $urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;

    // Saturation of cnt0
    do_reset();
    drive(1, 4'd0, 32'd1, 32'd1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65536; i++) cycle();
    check_eq("cnt0_saturated", {16'd0, cnt0}, 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
